// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch queue.
package fetch_pkg;

  localparam int unsigned FQ_XLEN   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Slot fields are sized for the default 32-bit PC/instruction build.
  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
    logic               misalign;
  } fq_slot_t;

  // Advance a wrap-bit pointer that counts modulo 2*depth.
  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr, input int unsigned depth);
    return (ptr + 8'd1) & 8'((2 * depth) - 1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: PC request, instruction-memory read port, decode handshake.
interface fetch_queue_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ILEN  = 32
);

  logic [WIDTH-1:0] pc_i;
  logic             pc_req_valid;
  logic             pc_req_ready;
  logic             flush_i;
  logic             imem_req_o;
  logic [WIDTH-1:0] imem_addr_o;
  logic             imem_rvalid_i;
  logic [ILEN-1:0]  imem_rdata_i;
  logic             instr_valid_o;
  logic             instr_ready_i;
  logic [ILEN-1:0]  instr_o;
  logic [WIDTH-1:0] instr_pc_o;
  logic             instr_misalign_o;

  // Surrounding pipeline (PC stage, memory, decode).
  modport master (
    output pc_i, pc_req_valid, flush_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  pc_req_ready, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
           instr_misalign_o
  );

  // The fetch queue itself.
  modport slave (
    input  pc_i, pc_req_valid, flush_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output pc_req_ready, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
           instr_misalign_o
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue with flush discard credits.
// Optional head misalignment flag: define FETCH_MISALIGN_CHECK_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ILEN  = 32
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  bus
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam logic [PW:0] CAP = (PW + 1)'(DEPTH);

  fq_slot_t         slot_q [DEPTH];
  logic [PW-1:0]    alloc_ptr, fill_ptr, rd_ptr, discard_cnt;
  logic [PW-1:0]    used, unfilled;
  logic [PW:0]      occupancy;
  logic             ready, accept, fill, drop, pop, head_valid;
  logic             in_misalign;
  fq_slot_t         head;

  always_comb begin
    used       = alloc_ptr - rd_ptr;
    unfilled   = alloc_ptr - fill_ptr;
    // Stale responses still owed by memory count against capacity.
    occupancy  = {1'b0, used} + {1'b0, discard_cnt};
    ready      = !bus.flush_i && (occupancy < CAP);
    accept     = bus.pc_req_valid && ready;
    head_valid = (fill_ptr != rd_ptr);
    pop        = head_valid && bus.instr_ready_i && !bus.flush_i;
    drop       = bus.imem_rvalid_i && (discard_cnt != '0);
    fill       = bus.imem_rvalid_i && (discard_cnt == '0) && !bus.flush_i;
    head       = slot_q[rd_ptr[IW-1:0]];
`ifdef FETCH_MISALIGN_CHECK_EN
    in_misalign = |bus.pc_i[1:0];
`else
    in_misalign = 1'b0;
`endif
  end

  assign bus.pc_req_ready     = ready;
  assign bus.imem_req_o       = accept;
  assign bus.imem_addr_o      = {bus.pc_i[WIDTH-1:2], 2'b00};
  assign bus.instr_valid_o    = head_valid;
  assign bus.instr_o          = head_valid ? head.instr[ILEN-1:0] : '0;
  assign bus.instr_pc_o       = head_valid ? head.pc[WIDTH-1:0]   : '0;
  assign bus.instr_misalign_o = head_valid && head.misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      discard_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else if (bus.flush_i) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      // Every unfilled read becomes a credit; a response arriving now is dropped
      // either against an existing credit or against the read it belonged to.
      discard_cnt <= discard_cnt + unfilled - PW'(bus.imem_rvalid_i);
    end else begin
      if (accept) begin
        slot_q[alloc_ptr[IW-1:0]].pc       <= FQ_XLEN'(bus.pc_i);
        slot_q[alloc_ptr[IW-1:0]].misalign <= in_misalign;
        alloc_ptr <= PW'(ptr_inc(8'(alloc_ptr), DEPTH));
      end
      if (fill) begin
        slot_q[fill_ptr[IW-1:0]].instr <= FQ_XLEN'(bus.imem_rdata_i);
        fill_ptr <= PW'(ptr_inc(8'(fill_ptr), DEPTH));
      end
      if (drop) begin
        discard_cnt <= discard_cnt - PW'(1);
      end
      if (pop) begin
        rd_ptr <= PW'(ptr_inc(8'(rd_ptr), DEPTH));
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// against a queue-level reference model and an in-order memory model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.WIDTH(32), .ILEN(32)) bus ();

  fetch_queue #(.WIDTH(32), .DEPTH(DEPTH), .ILEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: live fetches in program order, plus count of stale reads owed.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ent_t;
  ent_t q[$];
  int   stale;

  // Memory model: in-order responses with a release cycle.
  typedef struct {
    logic [31:0] d;
    int          t;
  } rsp_t;
  rsp_t mem[$];

  int cyc, lat, last_t;
  int nvec, nfail;
  bit last_acc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0BAD_F00D;
  endfunction

  function automatic bit exp_mis(input logic [31:0] pc);
`ifdef FETCH_MISALIGN_CHECK_EN
    return |pc[1:0];
`else
    return (pc == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered and left just after a falling edge.
  task automatic step(input bit v, input logic [31:0] pc, input bit fl, input bit rdy);
    bit rv, ready_exp, valid_exp, found;
    int unfilled, t;
    bus.pc_req_valid  = v;
    bus.pc_i          = pc;
    bus.flush_i       = fl;
    bus.instr_ready_i = rdy;
    rv = (mem.size() > 0) && (mem[0].t == cyc);
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rv ? mem[0].d : NOP_INSTR;
    #1;
    ready_exp = !fl && ((q.size() + stale) < DEPTH);
    valid_exp = (q.size() > 0) && q[0].filled;
    check("pc_req_ready", 32'(bus.pc_req_ready), 32'(ready_exp));
    check("imem_req", 32'(bus.imem_req_o), 32'(v && ready_exp));
    if (v) check("imem_addr", bus.imem_addr_o, {pc[31:2], 2'b00});
    check("instr_valid", 32'(bus.instr_valid_o), 32'(valid_exp));
    check("instr", bus.instr_o, valid_exp ? q[0].instr : 32'h0);
    check("instr_pc", bus.instr_pc_o, valid_exp ? q[0].pc : 32'h0);
    check("misalign", 32'(bus.instr_misalign_o), valid_exp ? 32'(exp_mis(q[0].pc)) : 32'h0);
    last_acc = bus.imem_req_o;

    if (rv) mem.pop_front();
    unfilled = 0;
    foreach (q[i]) if (!q[i].filled) unfilled++;
    if (fl) begin
      if (rv) check("no_overflow", 32'((stale + unfilled) > 0), 32'h1);
      stale = stale + unfilled - (rv ? 1 : 0);
      q.delete();
    end else begin
      if (valid_exp && rdy) void'(q.pop_front());
      if (rv) begin
        if (stale > 0) stale--;
        else begin
          found = 1'b0;
          foreach (q[i]) begin
            if (!found && !q[i].filled) begin
              q[i].instr  = mem_word({q[i].pc[31:2], 2'b00});
              q[i].filled = 1'b1;
              found       = 1'b1;
            end
          end
          check("no_overflow", 32'(found), 32'h1);
        end
      end
      if (v && ready_exp) q.push_back('{pc, 32'h0, 1'b0});
    end

    if (bus.imem_req_o) begin
      t = cyc + lat;
      if (t <= last_t) t = last_t + 1;
      mem.push_back('{mem_word(bus.imem_addr_o), t});
      last_t = t;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, 32'h0, 1'b0, rdy);
  endtask

  // Present a PC until accepted, as a stalled PC stage would.
  task automatic send(input logic [31:0] pc, input bit rdy);
    int n;
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 20) begin
      step(1'b1, pc, 1'b0, rdy);
      n++;
    end
    if (!last_acc) check("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pc_req_valid = 1'b0; bus.pc_i = '0; bus.flush_i = 1'b0;
    bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0; bus.instr_ready_i = 1'b0;
    mem.delete(); q.delete(); stale = 0; last_t = 0;
    @(negedge clk); cyc++;
    #1;
    check("rst_valid", 32'(bus.instr_valid_o), 32'h0);
    check("rst_instr", bus.instr_o, 32'h0);
    check("rst_pc", bus.instr_pc_o, 32'h0);
    check("rst_misalign", 32'(bus.instr_misalign_o), 32'h0);
    check("rst_req", 32'(bus.imem_req_o), 32'h0);
    @(negedge clk); cyc++;
    rst = 1'b0;
  endtask

  initial begin
    int acc, n;
    bit v, fl, rdy;
    logic [31:0] pc;
    nvec = 0; nfail = 0; cyc = 0; lat = 1; last_t = 0; stale = 0;
    do_reset();

    // Streaming, latency 1, decode always ready.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b1);
    idle(5, 1'b1);

    // Backpressure: decode stalled, six PCs offered, only DEPTH taken.
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'(i * 4), 1'b0, 1'b0);
      acc += int'(last_acc);
    end
    check("bp_accepts", 32'(acc), 32'(DEPTH));
    check("bp_ready_low", 32'(bus.pc_req_ready), 32'h0);
    idle(2, 1'b0);
    send(32'h10, 1'b1);
    send(32'h14, 1'b1);
    idle(8, 1'b1);

    // Flush with three reads in flight; the first post-flush PC must lead.
    lat = 4;
    send(32'h40, 1'b1); send(32'h44, 1'b1); send(32'h48, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    send(32'h100, 1'b1);
    n = 0;
    while (!bus.instr_valid_o && n < 20) begin
      idle(1, 1'b0);
      n++;
    end
    check("flush_first_pc", bus.instr_pc_o, 32'h100);
    idle(6, 1'b1);

    // Flush coinciding with a response while no credits are held.
    lat = 2;
    send(32'h200, 1'b1);
    idle(1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    idle(1, 1'b1);
    check("flush_rv_valid", 32'(bus.instr_valid_o), 32'h0);
    idle(3, 1'b1);

    // Accept, fill and pop together at used == DEPTH-1.
    lat = 1;
    step(1'b1, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'h308, 1'b0, 1'b0);
    step(1'b1, 32'h30C, 1'b0, 1'b1);
    idle(8, 1'b1);

    // Misaligned PC: aligned address issued, flag depends on build.
    step(1'b1, 32'h6, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("misalign_head", 32'(bus.instr_misalign_o), 32'(exp_mis(32'h6)));
    idle(3, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (mem.size() == 0 && ($urandom % 50) == 0) lat = int'($urandom_range(1, 5));
      v   = ($urandom % 4) != 0;
      pc  = $urandom;
      fl  = ($urandom % 25) == 0;
      rdy = ($urandom % 3) != 0;
      step(v, pc, fl, rdy);
    end

    // Reset in the middle of activity, then a short stream.
    lat = 3;
    send(32'h500, 1'b1); send(32'h504, 1'b1);
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) step(1'b1, 32'h600 + 32'(i * 4), 1'b0, 1'b1);
    idle(5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
